// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the hardware master that drives the 16-bit interval timer slave:
// slave register map, control bit positions and master FSM states.
package timer_ctrl_pkg;

  localparam logic [3:0] ADDR_STATUS  = 4'd0;
  localparam logic [3:0] ADDR_CONTROL = 4'd1;
  localparam logic [3:0] ADDR_PERIOD0 = 4'd2;
  localparam logic [3:0] ADDR_PERIOD1 = 4'd3;
  localparam logic [3:0] ADDR_PERIOD2 = 4'd4;
  localparam logic [3:0] ADDR_PERIOD3 = 4'd5;
  localparam logic [3:0] ADDR_SNAP0   = 4'd6;
  localparam logic [3:0] ADDR_SNAP1   = 4'd7;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [3:0] {
    IDLE, W_P0, W_P1, W_P2, W_P3, W_CTRL, RUN,
    W_CLR, W_STOP, W_SNAP, R_S0, R_S1, R_CAP
  } state_t;

  function automatic logic [15:0] ctrl_word(input logic ito, input logic cont,
                                            input logic start, input logic stop);
    logic [15:0] w;
    w = '0;
    w[CTRL_ITO]   = ito;
    w[CTRL_CONT]  = cont;
    w[CTRL_START] = start;
    w[CTRL_STOP]  = stop;
    return w;
  endfunction

endpackage

// File: rtl/timer_ctrl_master.sv
// Avalon-MM master that programs the interval timer, services its IRQ into a one-cycle
// tick, and reads back 32-bit counter snapshots without any software involvement.
module timer_ctrl_master
  import timer_ctrl_pkg::*;
#(
  parameter bit CONTINUOUS = 1'b1,
  parameter int TICK_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              snap_req,
  output logic              busy,
  output logic              running,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snap_value,
  output logic              snap_valid,
  output logic [3:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  input  logic              timer_irq
);

  state_t      state, state_nxt;
  logic        from_run;
  logic [31:0] period_q;
  logic [15:0] hw0_q;
  logic [31:0] snap_q;
  logic        stop_pend, snap_pend;
  logic        stop_any, snap_any;
  logic        stop_clr, snap_clr, start_acc;
  logic        wr;

  assign stop_any = stop_pend | cfg_stop;
  assign snap_any = snap_pend | snap_req;

  // Arbitration in the two resting states: irq service > stop > start > snap.
  always_comb begin
    state_nxt = state;
    stop_clr  = 1'b0;
    snap_clr  = 1'b0;
    start_acc = 1'b0;
    case (state)
      IDLE: begin
        if (stop_any) begin
          stop_clr = 1'b1;
        end else if (cfg_start) begin
          start_acc = 1'b1;
          state_nxt = W_P0;
        end else if (snap_any) begin
          snap_clr  = 1'b1;
          state_nxt = W_SNAP;
        end
      end
      RUN: begin
        if (timer_irq) begin
          state_nxt = W_CLR;
        end else if (stop_any) begin
          stop_clr  = 1'b1;
          state_nxt = W_STOP;
        end else if (cfg_start) begin
          start_acc = 1'b1;
          state_nxt = W_P0;
        end else if (snap_any) begin
          snap_clr  = 1'b1;
          state_nxt = W_SNAP;
        end
      end
      W_P0:    state_nxt = W_P1;
      W_P1:    state_nxt = W_P2;
      W_P2:    state_nxt = W_P3;
      W_P3:    state_nxt = W_CTRL;
      W_CTRL:  state_nxt = RUN;
      W_CLR:   state_nxt = CONTINUOUS ? RUN : IDLE;
      W_STOP:  state_nxt = IDLE;
      W_SNAP:  state_nxt = R_S0;
      R_S0:    state_nxt = R_S1;
      R_S1:    state_nxt = R_CAP;
      R_CAP:   state_nxt = from_run ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus decoded straight from the state register so reset releases it at once.
  always_comb begin
    wr            = 1'b0;
    avm_address   = ADDR_STATUS;
    avm_writedata = '0;
    case (state)
      W_P0:   begin wr = 1'b1; avm_address = ADDR_PERIOD0; avm_writedata = period_q[15:0];  end
      W_P1:   begin wr = 1'b1; avm_address = ADDR_PERIOD1; avm_writedata = period_q[31:16]; end
      W_P2:   begin wr = 1'b1; avm_address = ADDR_PERIOD2; end
      W_P3:   begin wr = 1'b1; avm_address = ADDR_PERIOD3; end
      W_CTRL: begin
        wr            = 1'b1;
        avm_address   = ADDR_CONTROL;
        avm_writedata = ctrl_word(1'b1, CONTINUOUS, 1'b1, 1'b0);
      end
      W_CLR:  begin wr = 1'b1; avm_address = ADDR_STATUS; end
      W_STOP: begin
        wr            = 1'b1;
        avm_address   = ADDR_CONTROL;
        avm_writedata = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
      end
      W_SNAP: begin wr = 1'b1; avm_address = ADDR_SNAP0; end
      R_S0:   avm_address = ADDR_SNAP0;
      R_S1:   avm_address = ADDR_SNAP1;
      default: ;
    endcase
  end

  assign avm_chipselect = wr;
  assign avm_write_n    = ~wr;
  assign busy           = (state != IDLE) && (state != RUN);
  assign running        = (state == RUN) || ((state != IDLE) && from_run);
  assign snap_valid     = (state == R_CAP);
  // The high halfword arrives during R_CAP, so the new snapshot is forwarded in that cycle.
  assign snap_value     = (state == R_CAP) ? {avm_readdata, hw0_q} : snap_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      from_run   <= 1'b0;
      period_q   <= '0;
      hw0_q      <= '0;
      snap_q     <= '0;
      stop_pend  <= 1'b0;
      snap_pend  <= 1'b0;
      tick       <= 1'b0;
      tick_count <= '0;
    end else begin
      state     <= state_nxt;
      stop_pend <= stop_any & ~stop_clr;
      snap_pend <= snap_any & ~snap_clr;
      tick      <= (state == W_CLR);
      if ((state == IDLE) || (state == RUN))
        from_run <= (state == RUN);
      if (start_acc) begin
        period_q   <= (cfg_period == 32'd0) ? 32'd1 : cfg_period;
        tick_count <= '0;
      end else if (state == W_CLR) begin
        tick_count <= tick_count + TICK_W'(1);
      end
      if (state == R_S1)
        hw0_q <= avm_readdata;
      if (state == R_CAP)
        snap_q <= {avm_readdata, hw0_q};
    end
  end

endmodule
